// File: rtl/data_memory_responder_pkg.sv
// Shared types for the data memory bus: lane masks, bus words and the read-response pipe entry.
package mem_bus_pkg;
  localparam int BYTE_LANES = 4;

  typedef logic [BYTE_LANES-1:0] lane_mask_t;
  typedef logic [31:0]           word_t;

  typedef struct packed {
    logic  valid;
    logic  error;
    word_t data;
  } rd_pipe_t;
endpackage

// File: rtl/data_memory_responder_if.sv
// Data memory bus between the load/store unit (master) and the memory responder (slave).
interface data_memory_responder_if;
  import mem_bus_pkg::*;

  logic [31:0] bus_address;
  word_t       bus_write_data;
  lane_mask_t  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  word_t       bus_read_data;
  logic        bus_read_valid;
  logic        bus_error;

  modport master (
    output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    input  bus_read_data, bus_read_valid, bus_error
  );

  modport slave (
    input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    output bus_read_data, bus_read_valid, bus_error
  );
endinterface

// File: rtl/data_memory_responder_read_latency_pipe.sv
// Fixed-depth read response delay line; DEPTH cycles, no backpressure.
// Each stage keeps its data until a valid entry replaces it, so the output data holds between pulses.
module read_latency_pipe
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clock,
  input  logic     reset_n,
  input  rd_pipe_t in_i,
  output rd_pipe_t out_o
);
  rd_pipe_t [DEPTH-1:0] stage_q;
  rd_pipe_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    stage_d[0].valid = in_i.valid;
    stage_d[0].error = in_i.error;
    if (in_i.valid) begin
      stage_d[0].data = in_i.data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k].valid = stage_q[k-1].valid;
      stage_d[k].error = stage_q[k-1].error;
      if (stage_q[k-1].valid) begin
        stage_d[k].data = stage_q[k-1].data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_o = stage_q[DEPTH-1];
endmodule

// File: rtl/data_memory_responder.sv
// Word-organised data RAM with byte-lane writes; reads answer after READ_LATENCY cycles, fully pipelined.
// No backpressure: one read and/or write accepted every cycle; faults pulse bus_error.
module data_memory_responder
  import mem_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 10,
  parameter logic [31:0] BASE_ADDRESS = 32'h0001_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  data_memory_responder_if.slave  bus
);
  localparam int WORDS   = 1 << ADDR_WIDTH;
  localparam int TAG_LSB = ADDR_WIDTH + 2;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be 1..4");
  end

  logic                        hit;
  logic                        fault;
  logic                        wr_en;
  logic [ADDR_WIDTH-1:0]       index;
  logic [BYTE_LANES-1:0][7:0]  mem_q [WORDS];
  rd_pipe_t                    pipe_in;
  rd_pipe_t                    pipe_out;
  logic                        wr_err_d;
  logic                        wr_err_q;
  logic                        unused_addr_bits;

  // Lane alignment travels on byte_enable, so the two low address bits carry nothing here.
  assign unused_addr_bits = ^bus.bus_address[1:0];

  assign hit   = bus.bus_address[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB];
  assign index = bus.bus_address[TAG_LSB-1:2];
  assign fault = !hit || (bus.bus_byte_enable == '0);
  assign wr_en = bus.bus_write_enable && !fault;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (bus.bus_byte_enable[i]) begin
          mem_q[index][i] <= bus.bus_write_data[8*i +: 8];
        end
      end
    end
  end

  // The read samples the array before this edge's write lands: same-cycle RW returns the old word.
  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = bus.bus_read_enable;
    pipe_in.error = bus.bus_read_enable && fault;
    if (bus.bus_read_enable && !fault) begin
      pipe_in.data = mem_q[index];
    end
  end

  read_latency_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_read_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .in_i    (pipe_in),
    .out_o   (pipe_out)
  );

  assign wr_err_d = bus.bus_write_enable && fault;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.bus_read_data  = pipe_out.data;
  assign bus.bus_read_valid = pipe_out.valid;
  assign bus.bus_error      = pipe_out.error | wr_err_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with READ_LATENCY=3 and the default 4 KiB window.
module tb_data_memory_responder;
  import mem_bus_pkg::*;

  localparam int          LAT  = 3;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clock = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  data_memory_responder_if bus_if ();

  data_memory_responder #(
    .ADDR_WIDTH   (10),
    .BASE_ADDRESS (BASE),
    .READ_LATENCY (LAT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] addr,
                       input word_t wd, input lane_mask_t be);
    bus_if.bus_read_enable  = re;
    bus_if.bus_write_enable = we;
    bus_if.bus_address      = addr;
    bus_if.bus_write_data   = wd;
    bus_if.bus_byte_enable  = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic write_word(input logic [31:0] addr, input word_t wd, input lane_mask_t be);
    drive(1'b0, 1'b1, addr, wd, be);
    tick();
    idle();
  endtask

  // Called just after the request edge; waits (bounded) for the response and checks it.
  task automatic wait_rsp(input string tag, input word_t exp_data, input logic exp_err);
    int n;
    n = 1;
    while (!bus_if.bus_read_valid && n < LAT + 4) begin
      tick();
      n++;
    end
    chk_eq({tag, " latency"}, 32'(n), 32'(LAT));
    chk_eq({tag, " data"}, bus_if.bus_read_data, exp_data);
    chk_eq({tag, " error"}, 32'(bus_if.bus_error), 32'(exp_err));
    tick();
    chk_eq({tag, " valid pulse"}, 32'(bus_if.bus_read_valid), 32'h0);
    chk_eq({tag, " data hold"}, bus_if.bus_read_data, exp_data);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr,
                            input word_t exp_data, input logic exp_err);
    drive(1'b1, 1'b0, addr, 32'h0, 4'hF);
    tick();
    idle();
    wait_rsp(tag, exp_data, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] t4 [4];
    logic        seen;
    logic        exp_v;
    t4[0] = 32'h0102_0304;
    t4[1] = 32'h1122_3344;
    t4[2] = 32'h5566_7788;
    t4[3] = 32'h99AA_BBCC;

    reset_n = 1'b0;
    idle();
    repeat (3) @(posedge clock);
    #1;
    chk_eq("reset valid", 32'(bus_if.bus_read_valid), 32'h0);
    chk_eq("reset error", 32'(bus_if.bus_error), 32'h0);
    chk_eq("reset data", bus_if.bus_read_data, 32'h0);
    #2 reset_n = 1'b1;
    tick();

    // Reset while a read is in flight: nothing may come out afterwards.
    drive(1'b1, 1'b0, BASE, 32'h0, 4'hF);
    tick();
    idle();
    reset_n = 1'b0;
    #4 reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      tick();
      seen = seen | bus_if.bus_read_valid | bus_if.bus_error;
    end
    chk_eq("rst_mid_read no response", 32'(seen), 32'h0);
    chk_eq("rst_mid_read data", bus_if.bus_read_data, 32'h0);

    // Byte-lane merge; the read directly follows the write.
    write_word(BASE + 32'h4, 32'hAABB_CCDD, 4'b1111);
    write_word(BASE + 32'h4, 32'h0000_1100, 4'b0010);
    read_check("lanes", BASE + 32'h4, 32'hAABB_11DD, 1'b0);

    // Same-cycle read and write to one word.
    write_word(BASE + 32'h8, 32'h0000_0001, 4'hF);
    drive(1'b1, 1'b1, BASE + 32'h8, 32'h0000_0002, 4'hF);
    tick();
    idle();
    wait_rsp("rw_same old", 32'h0000_0001, 1'b0);
    read_check("rw_same new", BASE + 32'h8, 32'h0000_0002, 1'b0);

    // Back-to-back reads of four consecutive words.
    for (int i = 0; i < 4; i++) begin
      write_word(BASE + 32'h10 + 32'(4 * i), t4[i], 4'hF);
    end
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(1'b1, 1'b0, BASE + 32'h10 + 32'(4 * c), 32'h0, 4'hF);
      else       idle();
      tick();
      exp_v = (c >= 2) && (c < 6);
      chk_eq($sformatf("b2b valid c%0d", c), 32'(bus_if.bus_read_valid), 32'(exp_v));
      if (exp_v) chk_eq($sformatf("b2b data c%0d", c), bus_if.bus_read_data, t4[c-2]);
    end

    // Faults: miss read, empty-mask write, and both at once.
    write_word(BASE, 32'h1234_5678, 4'hF);
    chk_eq("good write no error", 32'(bus_if.bus_error), 32'h0);
    read_check("base word", BASE, 32'h1234_5678, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF);
    tick();
    idle();
    chk_eq("dual_fault wr error", 32'(bus_if.bus_error), 32'h1);
    chk_eq("dual_fault early valid", 32'(bus_if.bus_read_valid), 32'h0);
    tick();
    chk_eq("dual_fault gap error", 32'(bus_if.bus_error), 32'h0);
    tick();
    chk_eq("dual_fault rd valid", 32'(bus_if.bus_read_valid), 32'h1);
    chk_eq("dual_fault rd error", 32'(bus_if.bus_error), 32'h1);
    chk_eq("dual_fault rd data", bus_if.bus_read_data, 32'h0);
    tick();
    chk_eq("dual_fault after error", 32'(bus_if.bus_error), 32'h0);
    read_check("miss read", 32'h0000_0000, 32'h0, 1'b1);
    write_word(BASE, 32'hFFFF_FFFF, 4'b0000);
    chk_eq("be0 write error", 32'(bus_if.bus_error), 32'h1);
    tick();
    chk_eq("be0 write error pulse", 32'(bus_if.bus_error), 32'h0);
    read_check("be0 ram unchanged", BASE, 32'h1234_5678, 1'b0);

    // Window boundary: last word is legal, one past it faults and does not alias to index 0.
    write_word(BASE + 32'h0FFC, 32'hCAFE_F00D, 4'hF);
    chk_eq("last word write no error", 32'(bus_if.bus_error), 32'h0);
    read_check("last word", BASE + 32'h0FFC, 32'hCAFE_F00D, 1'b0);
    write_word(BASE + 32'h1000, 32'hBAD0_BAD0, 4'hF);
    chk_eq("past end write error", 32'(bus_if.bus_error), 32'h1);
    tick();
    chk_eq("past end write error pulse", 32'(bus_if.bus_error), 32'h0);
    read_check("past end read", BASE + 32'h1000, 32'h0, 1'b1);
    read_check("no alias", BASE, 32'h1234_5678, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
